// File: rtl/cluster_input_frame_loader_if.sv
// Beat-stream input and held-frame output of the cluster input frame loader.
// slave is the loader side; master is the feeder/consumer side.
interface cluster_input_frame_loader_if #(
  parameter int FRAME_W = 1894,
  parameter int BEAT_W  = 64
);
  logic               s_valid;
  logic               s_ready;
  logic [BEAT_W-1:0]  s_data;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [FRAME_W-1:0] m_frame;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_frame
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_frame
  );
endinterface

// File: rtl/cluster_input_frame_loader.sv
// Assembles 64-bit beats into one wide cluster input vector and holds it for
// the combinational output-bit logic; one frame may assemble while another is held.
module cluster_input_frame_loader #(
  parameter int FRAME_W = 1894,
  parameter int BEAT_W  = 64,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cluster_input_frame_loader_if.slave bus,
  output logic                      err_len,
  output logic [CNT_W-1:0]          frame_cnt
);

  localparam int BEATS  = (FRAME_W + BEAT_W - 1) / BEAT_W;
  localparam int TAIL_W = FRAME_W - (BEATS - 1) * BEAT_W;
  localparam int IDX_W  = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {FILL, FULL, DISCARD} state_t;

  state_t             state;
  logic [IDX_W-1:0]   beat_idx;
  logic [FRAME_W-1:0] asm_buf;
  logic [FRAME_W-1:0] asm_next;
  logic               accept;
  logic               consume;

  always_comb bus.s_ready = rst_n && (state != FULL);

  assign accept  = bus.s_valid && bus.s_ready;
  assign consume = bus.m_valid && bus.m_ready;

  // Buffer contents with the current beat merged in; the final beat keeps only its low bits.
  always_comb begin
    asm_next = asm_buf;
    for (int unsigned k = 0; k < BEATS - 1; k++) begin
      if (beat_idx == IDX_W'(k))
        asm_next[k*BEAT_W +: BEAT_W] = bus.s_data;
    end
    if (beat_idx == LAST_IDX)
      asm_next[FRAME_W-1 -: TAIL_W] = bus.s_data[TAIL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= FILL;
      beat_idx    <= '0;
      asm_buf     <= '0;
      bus.m_valid <= 1'b0;
      bus.m_frame <= '0;
      err_len     <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      err_len <= 1'b0;
      // A consume clears m_valid unless a new frame is loaded below at the same edge.
      if (consume) begin
        frame_cnt   <= frame_cnt + 1'b1;
        bus.m_valid <= 1'b0;
      end
      unique case (state)
        FILL: begin
          if (accept) begin
            asm_buf <= asm_next;
            if (beat_idx == LAST_IDX) begin
              beat_idx <= '0;
              if (!bus.s_last) begin
                err_len <= 1'b1;
                state   <= DISCARD;
              end else if (!bus.m_valid || bus.m_ready) begin
                bus.m_frame <= asm_next;
                bus.m_valid <= 1'b1;
              end else begin
                state <= FULL;
              end
            end else if (bus.s_last) begin
              beat_idx <= '0;
              err_len  <= 1'b1;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
          end
        end
        FULL: begin
          if (bus.m_ready) begin
            bus.m_frame <= asm_buf;
            bus.m_valid <= 1'b1;
            state       <= FILL;
          end
        end
        DISCARD: begin
          if (accept && bus.s_last)
            state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_cluster_input_frame_loader.sv
// Directed-plus-random bench for cluster_input_frame_loader, checked against a
// frame-level model: a queue of pending frames and a list of beats collected so far.
module tb_cluster_input_frame_loader;

  localparam int FRAME_W = 1894;
  localparam int BEAT_W  = 64;
  localparam int CNT_W   = 16;
  localparam int BEATS   = 30;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             err_len;
  logic [CNT_W-1:0] frame_cnt;

  always #5 clk = ~clk;

  cluster_input_frame_loader_if #(.FRAME_W(FRAME_W), .BEAT_W(BEAT_W)) bus ();

  cluster_input_frame_loader #(
    .FRAME_W(FRAME_W),
    .BEAT_W (BEAT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .err_len  (err_len),
    .frame_cnt(frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [FRAME_W-1:0] exp_q[$];
  logic [BEAT_W-1:0]  cur[$];
  bit                 discarding;
  logic [CNT_W-1:0]   exp_cnt;
  int                 ready_mode;
  bit                 gaps;
  logic [BEAT_W-1:0]  last_beat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [FRAME_W-1:0] obs,
                           input logic [FRAME_W-1:0] exp);
    logic [BEATS*BEAT_W-1:0] wo, we;
    int bad;
    checks++;
    assert (obs === exp) else begin
      errors++;
      wo = '0; we = '0;
      wo[FRAME_W-1:0] = obs;
      we[FRAME_W-1:0] = exp;
      bad = 0;
      for (int k = BEATS - 1; k >= 0; k--)
        if (wo[k*BEAT_W +: BEAT_W] !== we[k*BEAT_W +: BEAT_W]) bad = k;
      $error("FAIL %s: beat %0d observed %h expected %h", tag, bad,
             wo[bad*BEAT_W +: BEAT_W], we[bad*BEAT_W +: BEAT_W]);
    end
  endtask

  function automatic logic [FRAME_W-1:0] build(input logic [BEAT_W-1:0] b[$]);
    logic [BEATS*BEAT_W-1:0] wide;
    wide = '0;
    foreach (b[k]) wide[k*BEAT_W +: BEAT_W] = b[k];
    return wide[FRAME_W-1:0];
  endfunction

  function automatic bit pick_ready();
    if (ready_mode == 0) return 1'b0;
    if (ready_mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: drive, check held state, advance model, check registered outputs.
  task automatic tick(input bit v, input logic [BEAT_W-1:0] d, input bit l, input bit mr,
                      output bit acc);
    bit cons, exp_err;
    @(negedge clk);
    bus.s_valid = v; bus.s_data = d; bus.s_last = l; bus.m_ready = mr;
    #1;
    chk("s_ready", bus.s_ready, 64'(rst_n && exp_q.size() < 2));
    chk("m_valid", bus.m_valid, 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk_frame("m_frame", bus.m_frame, exp_q[0]);
    acc  = v && rst_n && (exp_q.size() < 2);
    cons = mr && (exp_q.size() > 0);
    exp_err = 1'b0;
    if (cons) begin
      void'(exp_q.pop_front());
      exp_cnt++;
    end
    if (acc) begin
      if (discarding) begin
        if (l) discarding = 1'b0;
      end else begin
        cur.push_back(d);
        if (l) begin
          if (cur.size() == BEATS) exp_q.push_back(build(cur));
          else exp_err = 1'b1;
          cur.delete();
        end else if (cur.size() == BEATS) begin
          exp_err = 1'b1;
          discarding = 1'b1;
          cur.delete();
        end
      end
    end
    @(posedge clk);
    #1;
    chk("err_len", err_len, 64'(exp_err));
    chk("frame_cnt", frame_cnt, 64'(exp_cnt));
  endtask

  task automatic idle(input bit mr);
    bit acc;
    tick(1'b0, '0, 1'b0, mr, acc);
  endtask

  task automatic send_beat(input logic [BEAT_W-1:0] d, input bit l);
    bit acc, v;
    int tries;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 100) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick(v, d, l, pick_ready(), acc);
      tries++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: beat not accepted after %0d cycles, required acceptance", tries);
    end
  endtask

  task automatic send_frame(input int n, input int last_at, input bit pattern,
                            output logic [FRAME_W-1:0] f);
    logic [BEAT_W-1:0] b[$];
    logic [BEAT_W-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = pattern ? {32'hA5A5_0000 + 32'(k), 32'(k)} : {$urandom(), $urandom()};
      b.push_back(d);
      send_beat(d, k == last_at);
    end
    f = build(b);
    last_beat = d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      idle(1'b1);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout: %0d frames still pending, required 0", exp_q.size());
    end
  endtask

  task automatic do_reset(input bit v);
    @(negedge clk);
    rst_n = 1'b0;
    bus.s_valid = v; bus.s_data = {$urandom(), $urandom()}; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    #1;
    chk("rst_s_ready", bus.s_ready, 64'd0);
    @(posedge clk);
    #1;
    chk("rst_m_valid", bus.m_valid, 64'd0);
    chk_frame("rst_m_frame", bus.m_frame, '0);
    chk("rst_frame_cnt", frame_cnt, 64'd0);
    chk("rst_err_len", err_len, 64'd0);
    exp_q.delete();
    cur.delete();
    discarding = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.s_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FRAME_W-1:0] fa, fb, fx;
    int kind;
    rst_n = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    exp_cnt = '0; discarding = 1'b0; ready_mode = 1; gaps = 1'b0;

    // Reset state
    do_reset(1'b0);

    // 1: patterned frame, zero latency after final beat
    ready_mode = 1; gaps = 1'b0;
    send_frame(BEATS, BEATS - 1, 1'b1, fa);
    chk("t1_m_valid", bus.m_valid, 64'd1);
    chk("t1_lo", bus.m_frame[63:0], 64'hA5A5_0000_0000_0000);
    chk("t1_hi", bus.m_frame[FRAME_W-1:FRAME_W-38], last_beat[37:0]);
    idle(1'b1);
    chk("t1_cnt", frame_cnt, 64'd1);

    // 2: backpressure with two frames queued
    ready_mode = 0;
    send_frame(BEATS, BEATS - 1, 1'b0, fa);
    send_frame(BEATS, BEATS - 1, 1'b0, fb);
    chk("t2_s_ready_full", bus.s_ready, 64'd0);
    chk_frame("t2_hold_a", bus.m_frame, fa);
    idle(1'b1);
    chk_frame("t2_b", bus.m_frame, fb);
    chk("t2_s_ready_back", bus.s_ready, 64'd1);
    chk("t2_cnt", frame_cnt, 64'd2);
    idle(1'b0);
    idle(1'b1);
    chk("t2_cnt2", frame_cnt, 64'd3);

    // 3: early s_last on beat 10, then a good frame under random gaps/ready
    ready_mode = 1;
    send_frame(11, 10, 1'b0, fx);
    chk("t3_no_valid", bus.m_valid, 64'd0);
    ready_mode = 2; gaps = 1'b1;
    send_frame(BEATS, BEATS - 1, 1'b0, fx);
    drain();

    // 4: missing s_last, junk resync, good frame
    ready_mode = 1; gaps = 1'b0;
    send_frame(BEATS, -1, 1'b0, fx);
    send_frame(5, 4, 1'b0, fx);
    chk("t4_no_valid", bus.m_valid, 64'd0);
    send_frame(BEATS, BEATS - 1, 1'b0, fa);
    idle(1'b0);
    chk_frame("t4_good", bus.m_frame, fa);
    drain();

    // 5: reset during beat 15 of a frame while another is held
    ready_mode = 0;
    send_frame(BEATS, BEATS - 1, 1'b0, fa);
    send_frame(15, -1, 1'b0, fx);
    do_reset(1'b1);
    ready_mode = 1;
    send_frame(BEATS, BEATS - 1, 1'b0, fb);
    idle(1'b0);
    chk_frame("t5_fresh", bus.m_frame, fb);
    drain();

    // 6: frame counter wrap
    @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    exp_cnt = 16'hFFFF;
    chk("t6_preload", frame_cnt, 64'hFFFF);
    send_frame(BEATS, BEATS - 1, 1'b0, fa);
    drain();
    chk("t6_wrap", frame_cnt, 64'd0);

    // Random mix of good, short and unterminated frames
    ready_mode = 2; gaps = 1'b1;
    for (int i = 0; i < 10; i++) begin
      kind = int'($urandom_range(0, 5));
      if (kind == 0) begin
        send_frame(int'($urandom_range(1, BEATS - 1)), -2, 1'b0, fx);
        send_beat({$urandom(), $urandom()}, 1'b1);
      end else if (kind == 1) begin
        send_frame(BEATS, -1, 1'b0, fx);
        send_frame(int'($urandom_range(1, 3)), -2, 1'b0, fx);
        send_beat({$urandom(), $urandom()}, 1'b1);
      end else begin
        send_frame(BEATS, BEATS - 1, 1'b0, fx);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
